pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM) by generating write-enable, bubble and flush controls.
- Detects load-use hazards between EX and ID, flushes younger instructions on a taken branch resolved in EX, and holds EX for a multi-cycle multiply/divide.
- Keeps stall and flush event counters for performance debug.

Parameters:
- MULDIV_CYCLES, 4, total cycles a mul/div occupies EX; legal values ≥2.
- CNT_W, 16, width of the performance counters.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- EX_MemRead  in  1  EX instruction is a load.
- EX_Rt  in  5  load destination register of the EX instruction.
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
- EX_MulDivStart  in  1  EX instruction is a mul/div.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_Flush  out  1  clear IF/ID to a NOP.
- ID_EX_Write  out  1  ID/EX register load enable.
- ID_EX_Flush  out  1  load zeros into ID/EX control fields (bubble).
- EX_MEM_Flush  out  1  load zeros into EX/MEM control fields.
- MulDiv_Done  out  1  final EX cycle of a mul/div.
- StallCount  out  CNT_W  cycles with PCWrite=0 since reset; wraps.
- FlushCount  out  CNT_W  taken-branch flush events since reset; wraps.

Behaviour:
- Control outputs are combinational from state and inputs (same-cycle response). Counters and FSM are registered.
- Default (RUN, no event): PCWrite=1, IF_ID_Write=1, ID_EX_Write=1; all flushes 0; MulDiv_Done=0.
- While Rst=1:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Write=0.
  - IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1, MulDiv_Done=0.
  - Next state is RUN, cnt=0, StallCount=0, FlushCount=0. Reset aborts any mul/div in progress.
- FSM has two states, RUN and MD_BUSY, plus a down-counter cnt of width clog2(MULDIV_CYCLES).
- RUN priority, highest first:
  1. EX_BranchTaken=1: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1 (PC takes target). FlushCount+1. Load-use and EX_MulDivStart are ignored this cycle.
  2. EX_MulDivStart=1: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1. Set cnt<=MULDIV_CYCLES-2 and go to MD_BUSY.
  3. Load-use: the condition is EX_MemRead & EX_Rt!=0 & (EX_Rt==ID_Rs | (ID_UsesRt & EX_Rt==ID_Rt)). Response is PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; ID_EX_Write stays 1 so the bubble loads. Exactly one stall cycle results, because the load advances to MEM.
- MD_BUSY:
  - cnt≠0: same outputs as the RUN start cycle, and cnt decrements.
  - cnt==0: default outputs with MulDiv_Done=1, then return to RUN.
  - EX_MulDivStart stays high while ID/EX is held and is ignored in MD_BUSY. EX_BranchTaken and load-use are not evaluated.
- Resulting mul/div timing: EX occupancy is exactly MULDIV_CYCLES cycles; stall cycles are MULDIV_CYCLES-1.
  - With MULDIV_CYCLES=2, the FSM enters MD_BUSY with cnt=0, so MD_BUSY lasts one cycle.
  - Back-to-back mul/div: the second instruction enters EX in the cycle after MulDiv_Done and starts a new sequence.
- Register $0 never creates a load-use hazard.
- StallCount increments every cycle with Rst=0 and PCWrite=0. Both counters wrap modulo 2^CNT_W.
- EX_BranchTaken together with EX_MulDivStart is illegal, and the bench asserts against it. In RTL, the branch wins.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum {RUN, MD_BUSY};
  - the REG_ZERO=5'd0 constant;
  - a struct bundling the six pipeline control outputs, for reuse by other stage controllers.
- One natural sub-module, hazard_ld_use_cmp: the combinational load-use comparator.
- The FSM, cnt and counters stay in the top module.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 → one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, then defaults; StallCount=1.
- No hazard on $0 or unused rt: EX_Rt=0, ID_Rs=0 → defaults. Separately EX_Rt=7, ID_Rt=7, ID_UsesRt=0 → defaults.
- Taken branch with simultaneous load-use → IF_ID_Flush=ID_EX_Flush=1, PCWrite=1; FlushCount=1; StallCount unchanged.
- Mul/div with MULDIV_CYCLES=4, EX_MulDivStart held high → stall for 3 cycles, MulDiv_Done=1 on the 4th, RUN on the 5th; StallCount=3. Repeat with MULDIV_CYCLES=2 → 1 stall cycle, Done on the 2nd.
- Back-to-back mul/div → two full sequences separated only by the Done cycle; StallCount=6 (N=4).
- Rst asserted in MD_BUSY with cnt=1 → reset outputs that cycle; next cycle RUN with defaults, counters 0, no MulDiv_Done.
- Counter wrap with CNT_W=4 → 17 stall cycles give StallCount=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for pipeline stage controllers.
// Holds the hazard FSM state, the zero register and the control bundle.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctl_t;

  function automatic pipe_ctl_t ctl_default();
    pipe_ctl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1,
          if_id_flush: 1'b0, id_ex_write: 1'b1,
          id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
    return c;
  endfunction

  function automatic pipe_ctl_t ctl_reset();
    pipe_ctl_t c;
    c = '{pc_write: 1'b0, if_id_write: 1'b0,
          if_id_flush: 1'b1, id_ex_write: 1'b0,
          id_ex_flush: 1'b1, ex_mem_flush: 1'b1};
    return c;
  endfunction

  // Freeze front end and EX while mul/div owns EX.
  function automatic pipe_ctl_t ctl_hold();
    pipe_ctl_t c;
    c = '{pc_write: 1'b0, if_id_write: 1'b0,
          if_id_flush: 1'b0, id_ex_write: 1'b0,
          id_ex_flush: 1'b0, ex_mem_flush: 1'b1};
    return c;
  endfunction

endpackage

// File: rtl/hazard_ld_use_cmp.sv
// Load-use comparator between the load in EX and the source regs in ID.
// Register zero never produces a hazard.
module hazard_ld_use_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == rs);
  assign rt_hit = uses_rt & (ex_rt == rt);
  assign hazard = mem_read & (ex_rt != REG_ZERO)
                & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: load-use stall, branch flush,
// multi-cycle mul/div hold, plus stall/flush perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             EX_MulDivStart,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             MulDiv_Done,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned CW = $clog2(MULDIV_CYCLES);

  state_t    state;
  logic [CW-1:0] cnt;
  pipe_ctl_t ctl;
  logic      ld_use;
  logic      done;

  hazard_ld_use_cmp u_cmp (
    .mem_read (EX_MemRead),
    .ex_rt    (EX_Rt),
    .rs       (ID_Rs),
    .rt       (ID_Rt),
    .uses_rt  (ID_UsesRt),
    .hazard   (ld_use)
  );

  // Overlapping events resolve by priority: branch, mul/div, load-use.
  always_comb begin
    ctl  = ctl_default();
    done = 1'b0;
    if (Rst) begin
      ctl = ctl_reset();
    end else if (state == MD_BUSY) begin
      if (cnt != '0) ctl = ctl_hold();
      else           done = 1'b1;
    end else if (EX_BranchTaken) begin
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
    end else if (EX_MulDivStart) begin
      ctl = ctl_hold();
    end else if (ld_use) begin
      ctl.pc_write    = 1'b0;
      ctl.if_id_write = 1'b0;
      ctl.id_ex_flush = 1'b1;
    end
  end

  assign PCWrite      = ctl.pc_write;
  assign IF_ID_Write  = ctl.if_id_write;
  assign IF_ID_Flush  = ctl.if_id_flush;
  assign ID_EX_Write  = ctl.id_ex_write;
  assign ID_EX_Flush  = ctl.id_ex_flush;
  assign EX_MEM_Flush = ctl.ex_mem_flush;
  assign MulDiv_Done  = done;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= RUN;
      cnt        <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!EX_BranchTaken && EX_MulDivStart) begin
            state <= MD_BUSY;
            cnt   <= CW'(MULDIV_CYCLES - 2);
          end
        end
        MD_BUSY: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= RUN;
        end
        default: state <= RUN;
      endcase
      if (!ctl.pc_write)
        StallCount <= StallCount + CNT_W'(1);
      if (state == RUN && EX_BranchTaken)
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, two parameterisations
// (N=4/16-bit counters and N=2/4-bit counters) on shared stimulus.
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       ID_UsesRt, EX_MemRead, EX_BranchTaken, EX_MulDivStart;

  logic        pc4, ifw4, iff4, idw4, idf4, exf4, dn4;
  logic        pc2, ifw2, iff2, idw2, idf2, exf2, dn2;
  logic [15:0] st4, fl4;
  logic [3:0]  st2, fl2;
  logic [6:0]  o4, o2;

  int n_chk  = 0;
  int n_fail = 0;

  // {PCWrite,IF_ID_Write,IF_ID_Flush,ID_EX_Write,ID_EX_Flush,EX_MEM_Flush,Done}
  localparam logic [6:0] DEF  = 7'b1101000;
  localparam logic [6:0] RSTO = 7'b0010110;
  localparam logic [6:0] LU   = 7'b0001100;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] MD   = 7'b0000010;
  localparam logic [6:0] DONE = 7'b1101001;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(16)) u4 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .EX_MulDivStart(EX_MulDivStart),
    .PCWrite(pc4), .IF_ID_Write(ifw4), .IF_ID_Flush(iff4),
    .ID_EX_Write(idw4), .ID_EX_Flush(idf4), .EX_MEM_Flush(exf4),
    .MulDiv_Done(dn4), .StallCount(st4), .FlushCount(fl4)
  );

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(2), .CNT_W(4)) u2 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .EX_MulDivStart(EX_MulDivStart),
    .PCWrite(pc2), .IF_ID_Write(ifw2), .IF_ID_Flush(iff2),
    .ID_EX_Write(idw2), .ID_EX_Flush(idf2), .EX_MEM_Flush(exf2),
    .MulDiv_Done(dn2), .StallCount(st2), .FlushCount(fl2)
  );

  assign o4 = {pc4, ifw4, iff4, idw4, idf4, exf4, dn4};
  assign o2 = {pc2, ifw2, iff2, idw2, idf2, exf2, dn2};

  // Branch and mul/div in EX together is an illegal stimulus.
  always @(negedge Clk) begin
    if (Rst === 1'b0) begin
      assert (!(EX_BranchTaken && EX_MulDivStart)) else begin
        n_fail++;
        $error("FAIL illegal_br_md observed both high required not both");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
    EX_MemRead = 1'b0; EX_Rt = 5'd0;
    EX_BranchTaken = 1'b0; EX_MulDivStart = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    idle();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    // reset state
    Rst = 1'b1;
    idle();
    #2;
    chk("rst_out4", 32'(o4), 32'(RSTO));
    chk("rst_out2", 32'(o2), 32'(RSTO));
    tick();
    chk("rst_st4", 32'(st4), 0);
    chk("rst_fl4", 32'(fl4), 0);
    chk("rst_st2", 32'(st2), 0);
    chk("rst_fl2", 32'(fl2), 0);

    Rst = 1'b0;
    #2;
    chk("run_def", 32'(o4), 32'(DEF));
    tick();

    // load-use on rs
    EX_MemRead = 1'b1; EX_Rt = 5'd5; ID_Rs = 5'd5;
    #2;
    chk("lu_rs", 32'(o4), 32'(LU));
    tick();
    chk("lu_st", 32'(st4), 1);
    idle();
    #2;
    chk("lu_after", 32'(o4), 32'(DEF));
    tick();
    chk("lu_st_hold", 32'(st4), 1);

    // $0 and unused rt give no hazard
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    #2;
    chk("zero_reg", 32'(o4), 32'(DEF));
    tick();
    EX_Rt = 5'd7; ID_Rt = 5'd7; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
    #2;
    chk("rt_unused", 32'(o4), 32'(DEF));
    tick();
    ID_UsesRt = 1'b1;
    #2;
    chk("rt_used", 32'(o4), 32'(LU));
    tick();
    chk("rt_st", 32'(st4), 2);

    // branch beats simultaneous load-use
    EX_MemRead = 1'b1; EX_Rt = 5'd5; ID_Rs = 5'd5;
    EX_BranchTaken = 1'b1;
    #2;
    chk("br_lu", 32'(o4), 32'(BR));
    tick();
    chk("br_fl", 32'(fl4), 1);
    chk("br_st", 32'(st4), 2);
    idle();

    // mul/div N=4
    do_reset();
    EX_MulDivStart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("md4_stall%0d", i), 32'(o4), 32'(MD));
      tick();
    end
    #2;
    chk("md4_done", 32'(o4), 32'(DONE));
    tick();
    EX_MulDivStart = 1'b0;
    #2;
    chk("md4_run", 32'(o4), 32'(DEF));
    tick();
    chk("md4_st", 32'(st4), 3);

    // back-to-back mul/div N=4
    do_reset();
    EX_MulDivStart = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        #2;
        chk($sformatf("b2b_stall%0d_%0d", k, i), 32'(o4), 32'(MD));
        tick();
      end
      #2;
      chk($sformatf("b2b_done%0d", k), 32'(o4), 32'(DONE));
      tick();
    end
    EX_MulDivStart = 1'b0;
    #2;
    chk("b2b_run", 32'(o4), 32'(DEF));
    tick();
    chk("b2b_st", 32'(st4), 6);

    // mul/div N=2
    do_reset();
    EX_MulDivStart = 1'b1;
    #2;
    chk("md2_stall", 32'(o2), 32'(MD));
    tick();
    #2;
    chk("md2_done", 32'(o2), 32'(DONE));
    tick();
    EX_MulDivStart = 1'b0;
    #2;
    chk("md2_run", 32'(o2), 32'(DEF));
    tick();
    chk("md2_st", 32'(st2), 1);

    // reset while busy with cnt=1
    do_reset();
    EX_MulDivStart = 1'b1;
    tick();
    tick();
    #2;
    chk("mdrst_busy", 32'(o4), 32'(MD));
    Rst = 1'b1;
    #1;
    chk("mdrst_out", 32'(o4), 32'(RSTO));
    tick();
    Rst = 1'b0;
    EX_MulDivStart = 1'b0;
    #2;
    chk("mdrst_run", 32'(o4), 32'(DEF));
    chk("mdrst_st", 32'(st4), 0);
    chk("mdrst_fl", 32'(fl4), 0);
    tick();

    // StallCount wrap in the 4-bit instance
    do_reset();
    EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rs = 5'd9;
    repeat (17) tick();
    idle();
    #2;
    chk("wrap_st2", 32'(st2), 1);
    chk("wrap_st4", 32'(st4), 17);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
